cordic_share_ctrl: RTL and testbench
====================================

# cordic_share_ctrl

Shares one `Sine_Cosine_CORDIC` instance between `N_REQ` independent requesters. It arbitrates round-robin and forwards the winner's angle, operation and region flag. It drives the CORDIC `beg_fsm_cordic`/`ack_cordic` handshake, captures the result and flags, and returns them to the owning requester with a hold-until-acknowledged response. A watchdog aborts a transaction if the CORDIC never signals ready. The block sits between the floating-point trig consumers and the single CORDIC datapath.

## Interface
- `W`, 32, data width (single precision).
- `N_REQ`, 4, number of requesters (2..8).
- `TIMEOUT`, 255, maximum WAIT cycles before abort (≥ 1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `req`  in  N_REQ  per-requester request, level; hold with operands until `req_gnt`.
- `req_operation`  in  N_REQ  per requester: 1 = sine, 0 = cosine.
- `req_data`  in  N_REQ*W  angles in radians; slice i = `[i*W +: W]`.
- `req_region`  in  2*N_REQ  shift_region_flag per requester; slice i = `[2*i +: 2]`.
- `req_gnt`  out  N_REQ  one-hot, one-cycle pulse: operands of that requester accepted.
- `rsp_valid`  out  N_REQ  one-hot, response valid for the owner; held until `rsp_ack`.
- `rsp_ack`  in  N_REQ  owner acknowledges the response.
- `rsp_data`  out  W  result.
- `rsp_ovf`  out  1  result overflow flag.
- `rsp_unf`  out  1  result underflow flag.
- `rsp_err`  out  1  transaction aborted by watchdog.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cordic_beg`  out  1  to `beg_fsm_cordic`.
- `cordic_ack`  out  1  to `ack_cordic`.
- `cordic_operation`  out  1  to `operation`.
- `cordic_data_in`  out  W  to `data_in`.
- `cordic_region`  out  2  to `shift_region_flag`.
- `cordic_ready`  in  1  from `ready_cordic`; level, held until `cordic_ack`.
- `cordic_data_out`  in  W  from `data_output`.
- `cordic_ovf`, `cordic_unf`  in  1  from the overflow/underflow flags.

## Operation
States:
- IDLE: if any `req` bit is high, the arbiter picks the winner, starting the search at `(last_grant+1) mod N_REQ`. At that edge the block registers the owner index, operation, data and region, and moves to ISSUE. It stays in IDLE if `req` = 0.
- ISSUE (1 cycle):
  - `cordic_beg`=1 and `req_gnt[owner]`=1.
  - `last_grant` ← owner; watchdog counter ← 0.
  - Next state is WAIT.
- WAIT: watchdog counter increments each cycle.
  - If `cordic_ready`=1, register `cordic_data_out`, `cordic_ovf` and `cordic_unf`, and go to CAPTURE.
  - Otherwise, if counter == TIMEOUT, go to ABORT.
  - If ready and the timeout occur in the same cycle, ready wins.
- CAPTURE (1 cycle): `cordic_ack`=1 → RESPOND with `rsp_err`=0.
- ABORT (1 cycle): `cordic_ack`=1, `rsp_data`←0, `rsp_ovf`/`rsp_unf`←0, `rsp_err`←1 → RESPOND.
- RESPOND: `rsp_valid[owner]`=1 with stable data and flags. `rsp_ack[owner]`=1 → IDLE. `rsp_ack` bits of non-owners are ignored.

Datapath drive rules:
- `cordic_operation`, `cordic_data_in` and `cordic_region` come from registered operands.
- They are stable from ISSUE through CAPTURE/ABORT.
- They hold their last value in IDLE.

Other rules:
- `req` deasserted before it is granted is simply not served; there is no memory of it.
- A `req` still high when the block returns to IDLE counts as a new request.

Reset (`rst`=0, any state, including mid-transaction):
- State → IDLE; `last_grant` ← N_REQ-1, so requester 0 has first priority.
- All outputs are 0, including the `cordic_*` operand outputs.
- The CORDIC shares the same reset, so its in-flight operation is discarded.

## Timing
- Request seen in IDLE at edge t0 → ISSUE in cycle t0+1 (`cordic_beg`, `req_gnt`) → WAIT from t0+2.
- `cordic_ready` sampled high at edge tr → CAPTURE cycle (`cordic_ack`=1) → `rsp_valid` from tr+2.
- `rsp_ack` sampled at edge ta → IDLE at ta+1. A pending `req` re-issues at ta+2.
- Controller overhead is 4 cycles plus the CORDIC latency plus response hold time.
- Abort: `rsp_valid` with `rsp_err`=1 appears TIMEOUT+2 cycles after ISSUE when `cordic_ready` never rises.
- `cordic_beg`, `cordic_ack` and `req_gnt` are always single-cycle pulses.

## Structure
- Package `cordic_ctrl_pkg`:
  - state enum (IDLE, ISSUE, WAIT, CAPTURE, ABORT, RESPOND);
  - `OWNER_W = $clog2(N_REQ)`;
  - `TO_W = $clog2(TIMEOUT+1)`.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and `last_grant`, producing a one-hot grant and its index. The pointer register lives in the top level.
- All other logic lives in the top level: FSM, operand/result registers, watchdog counter.

## Test plan
Use a stub CORDIC with programmable latency L that returns `data_in ^ 32'hFFFF0000` and `ovf = data_in[0]`.
- **Single request:** `req[2]`=1, `data` `32'h3f91361e`, cos, region `2'b00`, L=20.
  - Required: `req_gnt`=`4'b0100` at ISSUE.
  - Required: `cordic_data_in`=`32'h3f91361e`.
  - Required: `rsp_valid[2]` with `rsp_data`=`32'hC06E361E`, `rsp_err`=0, 22 cycles after ISSUE.
- **Round robin:** all four `req` held continuously → grant order 0,1,2,3,0. No requester is granted twice while another waits.
- **Response hold:** delay `rsp_ack` for 10 cycles → `rsp_valid` and `rsp_data` remain stable; there is no new `cordic_beg` until `rsp_ack`.
- **Watchdog:** stub never raises ready, TIMEOUT=15.
  - Required: `cordic_ack` pulses once.
  - Required: `rsp_err`=1 and `rsp_data`=0, 17 cycles after ISSUE.
  - Required: the next request is served normally.
- **Ready on the timeout cycle:** L = TIMEOUT → CAPTURE path taken, `rsp_err`=0.
- **Reset mid-WAIT:** `rst`=0 for 2 cycles → all outputs 0. After release with `req`=`4'b1111`, the first grant goes to requester 0.

Source files
------------

// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
// Default configuration plus the controller state encoding.
package cordic_ctrl_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 255;

  localparam int OWNER_W = $clog2(DEF_N_REQ);
  localparam int TO_W    = $clog2(DEF_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ABORT   = 3'd4,
    S_RESPOND = 3'd5
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant.
// The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // First requester at or after last_grant+1, wrapping modulo N_REQ
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int cand;
      logic [IDX_W-1:0] cand_idx;
      cand     = (int'(last_grant) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end else begin
        gnt_any = gnt_any;
      end
    end
    if (gnt_any) begin
      gnt = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one Sine_Cosine_CORDIC between N_REQ requesters: round-robin issue,
// CORDIC handshake, watchdog abort and hold-until-ack response.
module cordic_share_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int N_REQ   = DEF_N_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_operation,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [2*N_REQ-1:0] req_region,
  output logic [N_REQ-1:0]   req_gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ack,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_ovf,
  output logic               rsp_unf,
  output logic               rsp_err,
  output logic               busy,
  output logic               cordic_beg,
  output logic               cordic_ack,
  output logic               cordic_operation,
  output logic [W-1:0]       cordic_data_in,
  output logic [1:0]         cordic_region,
  input  logic               cordic_ready,
  input  logic [W-1:0]       cordic_data_out,
  input  logic               cordic_ovf,
  input  logic               cordic_unf
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CW    = $clog2(TIMEOUT + 1);
  // Abort fires at the end of the TIMEOUT-th WAIT cycle.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_grant;
  logic [CW-1:0]    wd_cnt;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_any    (arb_any)
  );

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

  // Controller FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      owner            <= '0;
      last_grant       <= IDX_W'(N_REQ - 1);
      wd_cnt           <= '0;
      req_gnt          <= '0;
      rsp_valid        <= '0;
      rsp_data         <= '0;
      rsp_ovf          <= 1'b0;
      rsp_unf          <= 1'b0;
      rsp_err          <= 1'b0;
      busy             <= 1'b0;
      cordic_beg       <= 1'b0;
      cordic_ack       <= 1'b0;
      cordic_operation <= 1'b0;
      cordic_data_in   <= '0;
      cordic_region    <= 2'b00;
    end else begin
      req_gnt    <= '0;
      cordic_beg <= 1'b0;
      cordic_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            owner            <= arb_idx;
            cordic_operation <= req_operation[arb_idx];
            cordic_data_in   <= req_data[arb_idx*W +: W];
            cordic_region    <= req_region[2*arb_idx +: 2];
            req_gnt          <= arb_gnt;
            cordic_beg       <= 1'b1;
            busy             <= 1'b1;
            state            <= S_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          last_grant <= owner;
          wd_cnt     <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + CW'(1);
          // Ready takes priority over a simultaneous timeout
          if (cordic_ready) begin
            rsp_data   <= cordic_data_out;
            rsp_ovf    <= cordic_ovf;
            rsp_unf    <= cordic_unf;
            rsp_err    <= 1'b0;
            cordic_ack <= 1'b1;
            state      <= S_CAPTURE;
          end else if (wd_cnt == TO_LAST) begin
            cordic_ack <= 1'b1;
            state      <= S_ABORT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_CAPTURE: begin
          rsp_valid <= owner_oh;
          state     <= S_RESPOND;
        end
        S_ABORT: begin
          rsp_data  <= '0;
          rsp_ovf   <= 1'b0;
          rsp_unf   <= 1'b0;
          rsp_err   <= 1'b1;
          rsp_valid <= owner_oh;
          state     <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ack[owner]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_RESPOND;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Bench for cordic_share_ctrl with a latency-programmable CORDIC stub
// returning data_in ^ 32'hFFFF0000, ovf = data_in[0], unf = data_in[1].
module tb_cordic_share_ctrl;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 24;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_operation, rsp_ack;
  logic [N*W-1:0] req_data;
  logic [2*N-1:0] req_region;
  logic [N-1:0]   req_gnt, rsp_valid;
  logic [W-1:0]   rsp_data, cordic_data_in, cordic_data_out;
  logic           rsp_ovf, rsp_unf, rsp_err, busy;
  logic           cordic_beg, cordic_ack, cordic_operation;
  logic [1:0]     cordic_region;
  logic           cordic_ready, cordic_ovf, cordic_unf;

  always #5 clk = ~clk;

  cordic_share_ctrl #(.W(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_operation(req_operation),
    .req_data(req_data), .req_region(req_region), .req_gnt(req_gnt),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err), .busy(busy),
    .cordic_beg(cordic_beg), .cordic_ack(cordic_ack),
    .cordic_operation(cordic_operation), .cordic_data_in(cordic_data_in),
    .cordic_region(cordic_region), .cordic_ready(cordic_ready),
    .cordic_data_out(cordic_data_out), .cordic_ovf(cordic_ovf),
    .cordic_unf(cordic_unf)
  );

  // CORDIC stub: ready is high from cycle L after the ISSUE cycle until ack
  int         stub_lat   = 1;
  bit         stub_never = 1'b0;
  logic       stub_active;
  int         stub_cnt;
  logic [W-1:0] stub_din;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
      stub_din    <= '0;
    end else if (cordic_beg) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      stub_din    <= cordic_data_in;
    end else if (cordic_ack) begin
      stub_active <= 1'b0;
    end else if (stub_active) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign cordic_ready    = stub_active && !stub_never && (stub_cnt >= stub_lat);
  assign cordic_data_out = stub_din ^ 32'hFFFF0000;
  assign cordic_ovf      = stub_din[0];
  assign cordic_unf      = stub_din[1];

  int beg_cnt = 0;
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (cordic_beg) beg_cnt <= beg_cnt + 1;
    if (cordic_ack) ack_cnt <= ack_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [W-1:0] rr_word(input int i);
    return 32'h13570000 | 32'(i * 17 + 3);
  endfunction

  typedef struct {
    int          rq;
    logic        op;
    logic [31:0] data;
    logic [1:0]  region;
    int          lat;
    bit          never;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic        exp_unf;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit          ok;
    int          cyc, a0, b0;
    logic [N-1:0] oh;
    logic [W-1:0] d0;
    logic [N-1:0] v0;
    bit          stable;

    vecs[0] = '{2, 1'b0, 32'h3f91361e, 2'b00, 20, 1'b0, 32'hC06E361E, 1'b0, 1'b1, 1'b0, 22};
    vecs[1] = '{1, 1'b1, 32'h12345679, 2'b01, 3,  1'b0, 32'hEDCB5679, 1'b1, 1'b0, 1'b0, 5};
    vecs[2] = '{3, 1'b0, 32'h00000002, 2'b10, 1,  1'b0, 32'hFFFF0002, 1'b0, 1'b1, 1'b0, 3};
    vecs[3] = '{0, 1'b1, 32'hDEADBEEF, 2'b11, 0,  1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, TO + 2};
    vecs[4] = '{0, 1'b0, 32'h40490fdb, 2'b00, 5,  1'b0, 32'hBFB60FDB, 1'b1, 1'b1, 1'b0, 7};
    vecs[5] = '{1, 1'b1, 32'h00000000, 2'b01, TO, 1'b0, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, TO + 2};

    rst = 1'b0; req = '0; req_operation = '0; req_data = '0; req_region = '0; rsp_ack = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {req_gnt, rsp_valid, rsp_data, rsp_ovf, rsp_unf, rsp_err, busy,
                          cordic_beg, cordic_ack, cordic_operation, cordic_data_in, cordic_region}, '0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      stub_lat      = vecs[i].lat;
      stub_never    = vecs[i].never;
      req_data      = ~{N{vecs[i].data}};
      req_data[vecs[i].rq*W +: W] = vecs[i].data;
      req_operation = {N{~vecs[i].op}};
      req_operation[vecs[i].rq] = vecs[i].op;
      req_region    = ~{N{vecs[i].region}};
      req_region[2*vecs[i].rq +: 2] = vecs[i].region;
      oh = '0;
      oh[vecs[i].rq] = 1'b1;
      req = oh;
      wait_gnt(ok);
      check($sformatf("v%0d_gnt_seen", i), ok, 1'b1);
      check($sformatf("v%0d_req_gnt", i), req_gnt, oh);
      check($sformatf("v%0d_issue", i), {cordic_beg, busy}, 2'b11);
      check($sformatf("v%0d_operands", i), {cordic_operation, cordic_data_in, cordic_region},
            {vecs[i].op, vecs[i].data, vecs[i].region});
      a0  = ack_cnt;
      req = '0;
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), {req_gnt, cordic_beg}, '0);
      wait_rsp(400, cyc, ok);
      check($sformatf("v%0d_rsp_seen", i), ok, 1'b1);
      check($sformatf("v%0d_latency", i), cyc + 1, vecs[i].exp_cyc);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, oh);
      check($sformatf("v%0d_result", i), {rsp_data, rsp_ovf, rsp_unf, rsp_err},
            {vecs[i].exp_data, vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_err});
      check($sformatf("v%0d_ack_pulses", i), ack_cnt - a0, 1);
      // A non-owner ack must be ignored
      rsp_ack = ~oh;
      @(negedge clk);
      check($sformatf("v%0d_nonowner_ack", i), rsp_valid, oh);
      rsp_ack = oh;
      @(negedge clk);
      rsp_ack = '0;
      check($sformatf("v%0d_release", i), {rsp_valid, busy}, '0);
    end

    // Reset in the middle of WAIT
    stub_lat = 20; stub_never = 1'b0;
    req_data[3*W +: W] = 32'hA5A55A5B;
    req_operation = 4'b1000;
    req_region    = 8'b10000000;
    req = 4'b1000;
    wait_gnt(ok);
    check("rst_pre_gnt", req_gnt, 4'b1000);
    req = '0;
    repeat (5) @(negedge clk);
    check("rst_pre_busy", busy, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_outputs", {req_gnt, rsp_valid, rsp_data, rsp_ovf, rsp_unf, rsp_err, busy,
                              cordic_beg, cordic_ack, cordic_operation, cordic_data_in, cordic_region}, '0);

    // Round robin with all requests held, plus one delayed acknowledge
    stub_lat = 2;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = rr_word(i);
    req_operation = 4'b1010;
    req_region    = 8'b11100100;
    req = 4'b1111;
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      oh = '0;
      oh[t % N] = 1'b1;
      wait_gnt(ok);
      check($sformatf("rr%0d_gnt_seen", t), ok, 1'b1);
      check($sformatf("rr%0d_req_gnt", t), req_gnt, oh);
      check($sformatf("rr%0d_operands", t), {cordic_operation, cordic_data_in, cordic_region},
            {req_operation[t % N], rr_word(t % N), req_region[2*(t % N) +: 2]});
      wait_rsp(50, cyc, ok);
      check($sformatf("rr%0d_rsp_seen", t), ok, 1'b1);
      check($sformatf("rr%0d_rsp", t), {rsp_valid, rsp_data, rsp_err},
            {oh, rr_word(t % N) ^ 32'hFFFF0000, 1'b0});
      if (t == 2) begin
        d0 = rsp_data; v0 = rsp_valid; b0 = beg_cnt; stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (rsp_valid !== v0 || rsp_data !== d0) stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        check("hold_no_beg", beg_cnt - b0, 0);
      end
      rsp_ack = oh;
      @(negedge clk);
      rsp_ack = '0;
    end
    req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
